lkp_key_arb: RTL and testbench
==============================

Name: lkp_key_arb

Overview:
- Shares one lookup engine between two match stages (GME0, GME1).
- Each stage pushes 512-bit keys into a small per-port buffer. The block grants the lookup key port round-robin and records the requester ID of every issued key in an in-order tag FIFO.
- Index results return from lookup in issue order; the block steers each result back to the stage that issued the key.
- Sits between the match stages and the lookup engine, replacing their direct key/index wiring.

Parameters:
- KEY_FIFO_AW, 3, log2 depth of each per-port key buffer (depth 8).
- KEY_ALF_TH, 4, per-port key buffer occupancy at which out_arb_keyN_alf asserts.
- TAG_AW, 4, log2 depth of the tag FIFO (16 keys outstanding maximum).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_arb_key0  in  512  key from GME0
- in_arb_key0_wr  in  1  key0 valid
- out_arb_key0_alf  out  1  GME0 must stop sending keys
- in_arb_key1  in  512  key from GME1
- in_arb_key1_wr  in  1  key1 valid
- out_arb_key1_alf  out  1  GME1 must stop sending keys
- out_arb_key  out  512  key to lookup
- out_arb_key_wr  out  1  key valid to lookup
- in_arb_key_alf  in  1  lookup almost full
- in_arb_index  in  16  index result from lookup, in issue order
- in_arb_index_wr  in  1  index valid
- out_arb_index0  out  16  index to GME0
- out_arb_index0_wr  out  1  index0 valid
- out_arb_index1  out  16  index to GME1
- out_arb_index1_wr  out  1  index1 valid
- out_arb_grant_cnt0  out  32  keys issued for GME0
- out_arb_grant_cnt1  out  32  keys issued for GME1
- out_arb_status  out  32  {ovf0, ovf1, orphan, tag_full, 24'b0, tag_count[3:0]}

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs 0; out_arb_key=0.
  - Key buffers and tag FIFO empty; rr_last=1, so port 0 wins the first contention.
  - Sticky status bits cleared.
- Key buffering:
  - A buffer write on in_arb_keyN_wr=1 is accepted when the buffer is not full.
  - If the buffer is full, the key is dropped and sticky ovfN is set.
  - out_arb_keyN_alf is combinational: usedwN >= KEY_ALF_TH.
- Grant, evaluated every cycle:
  - eligible = !in_arb_key_alf && tag FIFO not full.
  - If eligible and exactly one port buffer is non-empty, grant that port.
  - If both are non-empty, grant the port != rr_last.
  - On a grant: pop the port's buffer head; on the next clock out_arb_key = head and out_arb_key_wr=1; push the port ID into the tag FIFO; set rr_last = granted port; increment grant_cntN (wraps at 2^32).
  - No grant: out_arb_key_wr=0 and out_arb_key holds its last value.
  - Throughput is one key per cycle. Key latency is 1 cycle from buffer head to output.
- Index return:
  - When in_arb_index_wr=1 and the tag FIFO is non-empty, pop the tag. On the next clock drive out_arb_indexT = in_arb_index with out_arb_indexT_wr=1 (T = popped tag).
  - The other port's wr is 0. Both index data outputs hold when not written.
  - If in_arb_index_wr=1 and the tag FIFO is empty, the index is dropped, sticky orphan is set, and no wr is driven.
- Simultaneous events:
  - A tag push and pop in the same cycle are both honoured; count is unchanged and the FIFO is never spuriously full.
  - A buffer write and a grant pop on the same port in the same cycle are both honoured, including when the buffer is full (pop frees the slot).
- tag_full status bit is the live tag-FIFO-full flag. tag_count[3:0] is the tag FIFO occupancy, saturating at 15 for the display only.
- Reset mid-operation: in-flight keys, tags and pending index outputs are discarded. The next lookup results after reset are treated as orphans.

Decomposition:
- Package lkp_arb_pkg holds:
  - constants KEY_W=512, IDX_W=16, CNT_W=32;
  - port ID encoding PORT0=1'b0, PORT1=1'b1;
  - status bit positions STS_OVF0=31, STS_OVF1=30, STS_ORPHAN=29, STS_TAGFULL=28.
- Sub-module sync_fifo (parameterised width/AW, async active-high reset, first-word-fall-through, usedw output):
  - two 512-bit instances for the key buffers;
  - one 1-bit instance for the tag FIFO.

Test Plan:
- Single port: 3 keys on port 0 (0xA1, 0xA2, 0xA3), lookup returns indices 0x0010, 0x0011, 0x0012 -> out_arb_key_wr pulses with A1, A2, A3 in order; out_arb_index0 = 0x0010, 0x0011, 0x0012; out_arb_index1_wr never asserts; grant_cnt0=3.
- Contention: both buffers hold 4 keys from reset -> grant order 0,1,0,1,0,1,0,1; returned indices 1..8 route alternately port0/port1; grant_cnt0=grant_cnt1=4.
- Backpressure: assert in_arb_key_alf for 10 cycles with 2 keys queued -> no out_arb_key_wr during alf; first key issues 1 cycle after alf drops.
- Tag full: issue 16 keys with no index returns, then 1 more queued -> 17th held, tag_full=1; one index return -> 17th key issues next eligible cycle.
- Overflow/alf: write 9 keys back-to-back to port 1 while in_arb_key_alf=1 -> out_arb_key1_alf=1 after the 4th write; 9th key dropped; status[30]=1.
- Orphan/reset: index with empty tag FIFO -> status[29]=1, no index wr. Assert rst mid-stream with 5 keys queued -> all outputs 0, status 0, counters 0.

Source files
------------

// File: rtl/lkp_arb_pkg.sv
// Shared constants for the lookup key arbiter: bus widths, port ID encoding
// and status register bit positions.
// No logic, no latency, no flow control.
package lkp_arb_pkg;

  localparam int KEY_W = 512;
  localparam int IDX_W = 16;
  localparam int CNT_W = 32;

  // Requester ID carried through the tag FIFO.
  typedef logic port_id_t;
  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  // Bit positions inside out_arb_status.
  localparam int STS_OVF0    = 31;
  localparam int STS_OVF1    = 30;
  localparam int STS_ORPHAN  = 29;
  localparam int STS_TAGFULL = 28;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy output.
// Latency: a write is visible on rdata/empty the cycle after it is taken.
// Backpressure: writes while full are ignored unless a read frees the slot in the same cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   wr, wdata       write strobe and data
//   rd              pop the head (ignored when empty)
//   rdata           current head (valid while !empty)
//   empty, full     occupancy flags
//   usedw           number of stored entries, 0 .. 2**AW
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  usedw
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (usedw == '0);
  assign full  = (usedw == DEPTH);
  assign rdata = mem[rptr];

  assign do_rd = rd && !empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
  assign do_wr = wr && (!full || do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      usedw <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   usedw <= usedw + (AW+1)'(1);
        2'b01:   usedw <= usedw - (AW+1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end

  // Storage is not reset; only entries between rptr and wptr are ever read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/lkp_key_arb.sv
// Shares one lookup engine between two match stages: round-robin key grant, in-order index return.
// Latency: 1 cycle buffer head -> out_arb_key; 1 cycle in_arb_index -> out_arb_indexN.
// Backpressure: no grant while in_arb_key_alf or tag FIFO full; out_arb_keyN_alf at buffer threshold.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_arb_keyN, in_arb_keyN_wr       key write from match stage N (N = 0, 1)
//   out_arb_keyN_alf                  match stage N must stop sending keys
//   out_arb_key, out_arb_key_wr       granted key to lookup
//   in_arb_key_alf                    lookup almost full, stalls the grant
//   in_arb_index, in_arb_index_wr     lookup result, returned in issue order
//   out_arb_indexN, out_arb_indexN_wr result steered back to the issuing stage
//   out_arb_grant_cntN                keys issued for stage N (wrapping)
//   out_arb_status                    {ovf0, ovf1, orphan, tag_full, 24'b0, tag_count[3:0]}
module lkp_key_arb
  import lkp_arb_pkg::*;
#(
  parameter int KEY_FIFO_AW = 3,
  parameter int KEY_ALF_TH  = 4,
  parameter int TAG_AW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] in_arb_key0,
  input  logic             in_arb_key0_wr,
  output logic             out_arb_key0_alf,
  input  logic [KEY_W-1:0] in_arb_key1,
  input  logic             in_arb_key1_wr,
  output logic             out_arb_key1_alf,
  output logic [KEY_W-1:0] out_arb_key,
  output logic             out_arb_key_wr,
  input  logic             in_arb_key_alf,
  input  logic [IDX_W-1:0] in_arb_index,
  input  logic             in_arb_index_wr,
  output logic [IDX_W-1:0] out_arb_index0,
  output logic             out_arb_index0_wr,
  output logic [IDX_W-1:0] out_arb_index1,
  output logic             out_arb_index1_wr,
  output logic [CNT_W-1:0] out_arb_grant_cnt0,
  output logic [CNT_W-1:0] out_arb_grant_cnt1,
  output logic [31:0]      out_arb_status
);

  localparam logic [KEY_FIFO_AW:0] ALF_LVL = (KEY_FIFO_AW+1)'(KEY_ALF_TH);
  localparam logic [TAG_AW:0]      CNT_SAT = (TAG_AW+1)'(15);

  logic [KEY_W-1:0]     head0, head1;
  logic                 empty0, empty1, full0, full1;
  logic [KEY_FIFO_AW:0] usedw0, usedw1;

  logic                 tag_empty, tag_full;
  port_id_t             tag_head;
  logic [TAG_AW:0]      tag_usedw;
  logic [3:0]           tag_count;

  logic                 eligible;
  logic                 grant;
  port_id_t             gnt_port;
  logic                 pop0, pop1;
  logic                 idx_pop;

  port_id_t             rr_last;
  logic                 ovf0, ovf1, orphan;

  sync_fifo #(.W(KEY_W), .AW(KEY_FIFO_AW)) u_key_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .wr    (in_arb_key0_wr),
    .wdata (in_arb_key0),
    .rd    (pop0),
    .rdata (head0),
    .empty (empty0),
    .full  (full0),
    .usedw (usedw0)
  );

  sync_fifo #(.W(KEY_W), .AW(KEY_FIFO_AW)) u_key_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .wr    (in_arb_key1_wr),
    .wdata (in_arb_key1),
    .rd    (pop1),
    .rdata (head1),
    .empty (empty1),
    .full  (full1),
    .usedw (usedw1)
  );

  // One entry per issued key, holding the requester ID, popped as results return.
  sync_fifo #(.W(1), .AW(TAG_AW)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (grant),
    .wdata (gnt_port),
    .rd    (idx_pop),
    .rdata (tag_head),
    .empty (tag_empty),
    .full  (tag_full),
    .usedw (tag_usedw)
  );

  assign out_arb_key0_alf = (usedw0 >= ALF_LVL);
  assign out_arb_key1_alf = (usedw1 >= ALF_LVL);

  // Tag full blocks the grant even if a pop lands in the same cycle; this keeps
  // the push from ever depending on the lookup's return timing.
  assign eligible = !in_arb_key_alf && !tag_full;

  always_comb begin
    grant    = 1'b0;
    gnt_port = PORT0;
    if (eligible) begin
      if (!empty0 && !empty1) begin
        grant    = 1'b1;
        gnt_port = ~rr_last;
      end else if (!empty0) begin
        grant    = 1'b1;
        gnt_port = PORT0;
      end else if (!empty1) begin
        grant    = 1'b1;
        gnt_port = PORT1;
      end
    end
  end

  assign pop0    = grant && (gnt_port == PORT0);
  assign pop1    = grant && (gnt_port == PORT1);
  assign idx_pop = in_arb_index_wr && !tag_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_arb_key        <= '0;
      out_arb_key_wr     <= 1'b0;
      rr_last            <= PORT1;
      out_arb_grant_cnt0 <= '0;
      out_arb_grant_cnt1 <= '0;
      out_arb_index0     <= '0;
      out_arb_index0_wr  <= 1'b0;
      out_arb_index1     <= '0;
      out_arb_index1_wr  <= 1'b0;
      ovf0               <= 1'b0;
      ovf1               <= 1'b0;
      orphan             <= 1'b0;
    end else begin
      out_arb_key_wr <= grant;
      if (grant) begin
        out_arb_key <= (gnt_port == PORT0) ? head0 : head1;
        rr_last     <= gnt_port;
      end
      if (pop0) out_arb_grant_cnt0 <= out_arb_grant_cnt0 + CNT_W'(1);
      if (pop1) out_arb_grant_cnt1 <= out_arb_grant_cnt1 + CNT_W'(1);

      out_arb_index0_wr <= idx_pop && (tag_head == PORT0);
      out_arb_index1_wr <= idx_pop && (tag_head == PORT1);
      if (idx_pop && (tag_head == PORT0)) out_arb_index0 <= in_arb_index;
      if (idx_pop && (tag_head == PORT1)) out_arb_index1 <= in_arb_index;

      // A write into a full buffer is lost only when the grant is not popping it.
      if (in_arb_key0_wr && full0 && !pop0) ovf0 <= 1'b1;
      if (in_arb_key1_wr && full1 && !pop1) ovf1 <= 1'b1;
      if (in_arb_index_wr && tag_empty)     orphan <= 1'b1;
    end
  end

  // Occupancy can reach 16, which does not fit the 4-bit display field.
  assign tag_count = (tag_usedw > CNT_SAT) ? 4'hF : tag_usedw[3:0];

  always_comb begin
    out_arb_status              = '0;
    out_arb_status[STS_OVF0]    = ovf0;
    out_arb_status[STS_OVF1]    = ovf1;
    out_arb_status[STS_ORPHAN]  = orphan;
    out_arb_status[STS_TAGFULL] = tag_full;
    out_arb_status[3:0]         = tag_count;
  end

endmodule

// File: tb/tb_lkp_key_arb.sv
module tb_lkp_key_arb;

  logic          clk;
  logic          rst;
  logic [511:0]  in_arb_key0;
  logic          in_arb_key0_wr;
  logic          out_arb_key0_alf;
  logic [511:0]  in_arb_key1;
  logic          in_arb_key1_wr;
  logic          out_arb_key1_alf;
  logic [511:0]  out_arb_key;
  logic          out_arb_key_wr;
  logic          in_arb_key_alf;
  logic [15:0]   in_arb_index;
  logic          in_arb_index_wr;
  logic [15:0]   out_arb_index0;
  logic          out_arb_index0_wr;
  logic [15:0]   out_arb_index1;
  logic          out_arb_index1_wr;
  logic [31:0]   out_arb_grant_cnt0;
  logic [31:0]   out_arb_grant_cnt1;
  logic [31:0]   out_arb_status;

  int total = 0;
  int bad   = 0;

  logic [511:0] exp_key [$];
  logic [16:0]  exp_idx [$];   // {port, index}

  logic [511:0] mon_key;
  logic [16:0]  mon_idx;

  lkp_key_arb dut (
    .clk                (clk),
    .rst                (rst),
    .in_arb_key0        (in_arb_key0),
    .in_arb_key0_wr     (in_arb_key0_wr),
    .out_arb_key0_alf   (out_arb_key0_alf),
    .in_arb_key1        (in_arb_key1),
    .in_arb_key1_wr     (in_arb_key1_wr),
    .out_arb_key1_alf   (out_arb_key1_alf),
    .out_arb_key        (out_arb_key),
    .out_arb_key_wr     (out_arb_key_wr),
    .in_arb_key_alf     (in_arb_key_alf),
    .in_arb_index       (in_arb_index),
    .in_arb_index_wr    (in_arb_index_wr),
    .out_arb_index0     (out_arb_index0),
    .out_arb_index0_wr  (out_arb_index0_wr),
    .out_arb_index1     (out_arb_index1),
    .out_arb_index1_wr  (out_arb_index1_wr),
    .out_arb_grant_cnt0 (out_arb_grant_cnt0),
    .out_arb_grant_cnt1 (out_arb_grant_cnt1),
    .out_arb_status     (out_arb_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  function automatic logic [511:0] mk(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_arb_key0_wr  = 1'b0;
    in_arb_key1_wr  = 1'b0;
    in_arb_index_wr = 1'b0;
    in_arb_key_alf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_key.delete();
    exp_idx.delete();
    rst = 1'b0;
    step();
  endtask

  task automatic push_key(input logic port, input logic [7:0] b);
    if (port) begin
      in_arb_key1 = mk(b); in_arb_key1_wr = 1'b1;
    end else begin
      in_arb_key0 = mk(b); in_arb_key0_wr = 1'b1;
    end
    step();
    in_arb_key0_wr = 1'b0;
    in_arb_key1_wr = 1'b0;
  endtask

  task automatic ret_idx(input logic port, input logic [15:0] idx);
    exp_idx.push_back({port, idx});
    in_arb_index    = idx;
    in_arb_index_wr = 1'b1;
    step();
    in_arb_index_wr = 1'b0;
  endtask

  task automatic wait_keys(input string name, input int budget);
    int n = 0;
    while (exp_key.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, exp_key.size(), 0);
  endtask

  task automatic wait_idx(input string name, input int budget);
    int n = 0;
    while (exp_idx.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, exp_idx.size(), 0);
  endtask

  // Monitor: every DUT output beat is matched against the head of its scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_arb_key_wr) begin
        if (exp_key.size() == 0) begin
          total++; bad++;
          $display("FAIL key_unexpected got=%0h want=none", out_arb_key);
        end else begin
          mon_key = exp_key.pop_front();
          chk("key_data", out_arb_key, mon_key);
        end
      end
      if (out_arb_index0_wr || out_arb_index1_wr) begin
        if (exp_idx.size() == 0) begin
          total++; bad++;
          $display("FAIL idx_unexpected got=%0h/%0h want=none", out_arb_index0, out_arb_index1);
        end else begin
          mon_idx = exp_idx.pop_front();
          chk("idx_route", {out_arb_index1_wr, out_arb_index0_wr}, mon_idx[16] ? 2'b10 : 2'b01);
          chk("idx_data", mon_idx[16] ? out_arb_index1 : out_arb_index0, mon_idx[15:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_arb_key0 = '0; in_arb_key0_wr = 1'b0;
    in_arb_key1 = '0; in_arb_key1_wr = 1'b0;
    in_arb_key_alf = 1'b0;
    in_arb_index = '0; in_arb_index_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_key",      out_arb_key, 0);
    chk("rst_key_wr",   out_arb_key_wr, 0);
    chk("rst_alf",      {out_arb_key0_alf, out_arb_key1_alf}, 0);
    chk("rst_idx_wr",   {out_arb_index0_wr, out_arb_index1_wr}, 0);
    chk("rst_idx",      {out_arb_index0, out_arb_index1}, 0);
    chk("rst_cnt",      {out_arb_grant_cnt0, out_arb_grant_cnt1}, 0);
    chk("rst_status",   out_arb_status, 0);
    rst = 1'b0;
    step();

    // Single port
    exp_key.push_back(mk(8'hA1));
    exp_key.push_back(mk(8'hA2));
    exp_key.push_back(mk(8'hA3));
    push_key(1'b0, 8'hA1);
    push_key(1'b0, 8'hA2);
    push_key(1'b0, 8'hA3);
    wait_keys("single_keys_done", 10);
    chk("single_tagcnt", out_arb_status, 32'h0000_0003);
    ret_idx(1'b0, 16'h0010);
    ret_idx(1'b0, 16'h0011);
    ret_idx(1'b0, 16'h0012);
    wait_idx("single_idx_done", 10);
    chk("single_cnt0", out_arb_grant_cnt0, 3);
    chk("single_cnt1", out_arb_grant_cnt1, 0);
    chk("single_status", out_arb_status, 0);

    // Contention: port 0 wins first after reset, then strict alternation
    do_reset();
    in_arb_key_alf = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_key.push_back(mk(8'hB0 + 8'(i)));
      exp_key.push_back(mk(8'hC0 + 8'(i)));
      in_arb_key0 = mk(8'hB0 + 8'(i)); in_arb_key0_wr = 1'b1;
      in_arb_key1 = mk(8'hC0 + 8'(i)); in_arb_key1_wr = 1'b1;
      step();
    end
    in_arb_key0_wr = 1'b0;
    in_arb_key1_wr = 1'b0;
    chk("cont_alf_both", {out_arb_key0_alf, out_arb_key1_alf}, 2'b11);
    in_arb_key_alf = 1'b0;
    wait_keys("cont_keys_done", 20);
    for (int i = 0; i < 8; i++) ret_idx(1'(i % 2), 16'(i + 1));
    wait_idx("cont_idx_done", 10);
    chk("cont_cnt0", out_arb_grant_cnt0, 4);
    chk("cont_cnt1", out_arb_grant_cnt1, 4);

    // Backpressure
    in_arb_key_alf = 1'b1;
    step();
    exp_key.push_back(mk(8'hD1));
    exp_key.push_back(mk(8'hD2));
    push_key(1'b0, 8'hD1);
    push_key(1'b1, 8'hD2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_no_issue", out_arb_key_wr, 0);
    end
    in_arb_key_alf = 1'b0;
    @(negedge clk);
    chk("bp_first_issue", out_arb_key_wr, 1);
    wait_keys("bp_keys_done", 10);
    ret_idx(1'b0, 16'h0021);
    ret_idx(1'b1, 16'h0022);
    wait_idx("bp_idx_done", 10);

    // Tag FIFO full
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp_key.push_back(mk(8'h40 + 8'(i)));
      push_key(1'b0, 8'h40 + 8'(i));
    end
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tagfull_held", out_arb_key_wr, 0);
    end
    chk("tagfull_status", out_arb_status, 32'h1000_000F);
    chk("tagfull_cnt0", out_arb_grant_cnt0, 16);
    chk("tagfull_pending", exp_key.size(), 1);
    ret_idx(1'b0, 16'h0100);
    wait_keys("tagfull_17th_issue", 5);
    chk("tagfull_cnt0_17", out_arb_grant_cnt0, 17);
    for (int i = 0; i < 16; i++) ret_idx(1'b0, 16'h0101 + 16'(i));
    wait_idx("tagfull_idx_done", 10);
    chk("tagfull_drained", out_arb_status, 0);

    // Overflow / almost-full on port 1
    in_arb_key_alf = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_key.push_back(mk(8'hE0 + 8'(i)));
      in_arb_key1 = mk(8'hE0 + 8'(i));
      in_arb_key1_wr = 1'b1;
      step();
      if (i == 2) chk("ovf_alf_below", out_arb_key1_alf, 0);
      if (i == 3) chk("ovf_alf_at_th", out_arb_key1_alf, 1);
      if (i == 7) chk("ovf_not_yet", out_arb_status[30], 0);
    end
    in_arb_key1_wr = 1'b0;
    chk("ovf_sticky", out_arb_status[31:30], 2'b01);
    in_arb_key_alf = 1'b0;
    wait_keys("ovf_keys_done", 20);
    for (int i = 0; i < 8; i++) ret_idx(1'b1, 16'h0300 + 16'(i));
    wait_idx("ovf_idx_done", 10);
    chk("ovf_cnt1", out_arb_grant_cnt1, 8);

    // Orphan index
    in_arb_index = 16'hDEAD;
    in_arb_index_wr = 1'b1;
    step();
    in_arb_index_wr = 1'b0;
    @(negedge clk);
    chk("orphan_no_wr", {out_arb_index0_wr, out_arb_index1_wr}, 0);
    chk("orphan_sticky", out_arb_status[29], 1);

    // Reset mid-stream: two keys outstanding, five queued, one result in flight
    exp_key.push_back(mk(8'h71));
    exp_key.push_back(mk(8'h72));
    push_key(1'b1, 8'h71);
    push_key(1'b1, 8'h72);
    wait_keys("mid_keys_done", 10);
    in_arb_key_alf = 1'b1;
    for (int i = 0; i < 5; i++) push_key(1'b0, 8'h80 + 8'(i));
    chk("mid_alf0_before", out_arb_key0_alf, 1);
    in_arb_index = 16'h4444;
    in_arb_index_wr = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_arb_index_wr = 1'b0;
    #1;
    chk("mid_key",    out_arb_key, 0);
    chk("mid_key_wr", out_arb_key_wr, 0);
    chk("mid_alf",    {out_arb_key0_alf, out_arb_key1_alf}, 0);
    chk("mid_idx",    {out_arb_index0, out_arb_index1}, 0);
    chk("mid_idx_wr", {out_arb_index0_wr, out_arb_index1_wr}, 0);
    chk("mid_cnt",    {out_arb_grant_cnt0, out_arb_grant_cnt1}, 0);
    chk("mid_status", out_arb_status, 0);
    exp_key.delete();
    exp_idx.delete();
    step();
    rst = 1'b0;
    in_arb_key_alf = 1'b0;
    repeat (5) step();
    ret_idx(1'b1, 16'h5555);
    exp_idx.delete();
    @(negedge clk);
    chk("post_rst_orphan", out_arb_status[29], 1);
    chk("post_rst_no_wr", {out_arb_index0_wr, out_arb_index1_wr}, 0);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
